seq_divider: RTL and testbench

- Sequential signed divider; the inverse of the team's 16x16 sequential Booth multiplier.
- Divides a 2*W-bit signed dividend by a W-bit signed divisor, one quotient bit per clock, using restoring division on magnitudes followed by a sign-fix cycle.
- Sits beside the multiplier in the execute-stage mult/div unit and uses the same start/ready handshake style.

---
 rtl/seq_divider.sv | 200 ++++++++++++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential signed divider for the execute-stage mult/div unit. Divides a
// 2*W-bit signed dividend by a W-bit signed divisor using restoring division
// on magnitudes, one quotient bit per clock, followed by one sign-fix cycle.
// Divide-by-zero and quotients that obviously cannot fit in W bits skip the
// iteration and finish right after the capture edge.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE; must drop before the next op
//   a          signed dividend (2*W bits)
//   b          signed divisor (W bits)
//   busy       high while iterating (CALC) or fixing signs (FIX)
//   ready      high in DONE; quotient/remainder/ovf/dbz are valid
//   quotient   signed quotient, truncated toward zero
//   remainder  signed remainder, same sign as the dividend
//   ovf        quotient not representable in W-bit signed, or divide-by-zero
//   dbz        divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*W-1:0]   a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             ready,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             ovf,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  localparam int            SW        = (W > 1) ? $clog2(W) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);
  // Largest positive and magnitude of the most negative W-bit signed value.
  localparam logic [W-1:0]  MAX_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_MAG   = {1'b1, {(W-1){1'b0}}};

  state_e        state_q, state_d;
  logic [SW-1:0] step_q,  step_d;
  // The W+1-bit partial remainder always has MSB 0 between iterations
  // (it is strictly below |b| <= 2^(W-1)), so only W bits are stored.
  logic [W-1:0]  pr_q,    pr_d;
  logic [W-1:0]  qw_q,    qw_d;
  logic [W-1:0]  bmag_q,  bmag_d;
  logic          sa_q,    sa_d;
  logic          sb_q,    sb_d;
  logic [W-1:0]  quot_q,  quot_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic          ovf_q,   ovf_d;
  logic          dbz_q,   dbz_d;

  // Magnitudes of the live inputs. -2^(2W-1) negates to itself, which read
  // as unsigned is exactly its magnitude.
  logic [2*W-1:0] a_mag;
  logic [W-1:0]   b_mag;
  assign a_mag = a[2*W-1] ? -a : a;
  assign b_mag = b[W-1]   ? -b : b;

  // One restoring step: shift {PR,Q} left, trial-subtract |b|.
  logic [W:0] pr_sh;
  logic [W:0] trial;
  assign pr_sh = {pr_q, qw_q[W-1]};
  assign trial = pr_sh - {1'b0, bmag_q};

  // Sign fix and final range check on the magnitude quotient.
  logic [W-1:0] q_signed;
  logic [W-1:0] r_signed;
  logic         fix_ovf;
  assign q_signed = (sa_q ^ sb_q) ? -qw_q : qw_q;
  assign r_signed = sa_q ? -pr_q : pr_q;
  assign fix_ovf  = (sa_q == sb_q) ? (qw_q > MAX_POS) : (qw_q > MIN_MAG);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      pr_q    <= '0;
      qw_q    <= '0;
      bmag_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pr_q    <= pr_d;
      qw_q    <= qw_d;
      bmag_q  <= bmag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    // NOTE: every target gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    step_d  = step_q;
    pr_d    = pr_q;
    qw_d    = qw_q;
    bmag_d  = bmag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d   = a[2*W-1];
          sb_d   = b[W-1];
          bmag_d = b_mag;
          step_d = '0;
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (b == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b1;
            quot_d  = '0;
            rem_d   = a[W-1:0];
            state_d = DONE;
          end else if (a_mag[2*W-1:W] >= b_mag) begin
            // Upper half alone already holds |b|: magnitude quotient >= 2^W.
            ovf_d   = 1'b1;
            quot_d  = '0;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            pr_d    = a_mag[2*W-1:W];
            qw_d    = a_mag[W-1:0];
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[W]) begin
          pr_d = trial[W-1:0];
          qw_d = {qw_q[W-2:0], 1'b1};
        end else begin
          pr_d = pr_sh[W-1:0];
          qw_d = {qw_q[W-2:0], 1'b0};
        end
        step_d = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          state_d = FIX;
        end
      end

      FIX: begin
        ovf_d   = fix_ovf;
        quot_d  = fix_ovf ? '0 : q_signed;
        rem_d   = fix_ovf ? '0 : r_signed;
        state_d = DONE;
      end

      DONE: begin
        // Results hold; a new request needs start to drop first.
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign ready     = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed bench for seq_divider (W=16). Each operation pushes its expected
// result onto a scoreboard queue; an independent monitor pops and compares
// whenever ready rises. The stimulus side checks latency, busy duration and
// the DONE/IDLE handshake.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;
  logic           dbz;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic ready_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare results against the scoreboard on every ready rise.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending op");
      end else begin
        mon_e = sb_q.pop_front();
        check("quotient",  32'(quotient),  32'(mon_e.q));
        check("remainder", 32'(remainder), 32'(mon_e.r));
        check("ovf",       32'(ovf),       32'(mon_e.ovf));
        check("dbz",       32'(dbz),       32'(mon_e.dbz));
      end
    end
    ready_prev = ready;
  end

  // Issue one operation. exp_edges is the number of clock edges after the
  // capture edge until ready is seen (W+1 normally, 0 for the shortcuts);
  // busy must be high on exactly that many cycles.
  task automatic run_op(input string name, input logic [31:0] aa, input logic [15:0] bb,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic eo, input logic ed, input int exp_edges,
                        input bit hold, input bit scramble);
    exp_t e;
    int   edges;
    int   busy_cnt;
    e.q = eq; e.r = er; e.ovf = eo; e.dbz = ed;
    sb_q.push_back(e);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    while (!ready && edges < 100) begin
      if (busy) busy_cnt++;
      if (scramble && edges == 5) begin
        a = 32'h1234_5678;
        b = 16'h0003;
      end
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"},     32'(edges),    32'(exp_edges));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edges));
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        check({name, "_hold_ready"}, 32'(ready),    32'd1);
        check({name, "_hold_busy"},  32'(busy),     32'd0);
        check({name, "_hold_quot"},  32'(quotient), 32'(eq));
      end
      start = 1'b0;
    end
    @(negedge clk);
    check({name, "_idle_ready"}, 32'(ready),     32'd0);
    check({name, "_idle_quot"},  32'(quotient),  32'(eq));
    check({name, "_idle_rem"},   32'(remainder), 32'(er));
    check({name, "_idle_ovf"},   32'(ovf),       32'(eo));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(ready),     32'd0);
    check("rst_quot",  32'(quotient),  32'd0);
    check("rst_rem",   32'(remainder), 32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    check("rst_dbz",   32'(dbz),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name          a              b         q         r         ovf   dbz  edges hold scr
    run_op("pos_pos",    32'd100,       16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("pos_neg",    32'd100,       16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("neg_pos",    32'hFFFFFF9C,  16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("neg_neg",    32'hFFFFFF9C,  16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("min_quot",   32'hFFFF8000,  16'd1,    16'h8000, 16'h0000, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("q_ovf_pos",  32'h00008000,  16'd1,    16'h0000, 16'h0000, 1'b1, 1'b0, 17, 1'b0, 1'b0);
    run_op("q_ovf_neg",  32'hFFFF7FFF,  16'd1,    16'h0000, 16'h0000, 1'b1, 1'b0, 17, 1'b0, 1'b0);
    run_op("mag_ovf",    32'h7FFFFFFF,  16'd2,    16'h0000, 16'h0000, 1'b1, 1'b0, 0,  1'b0, 1'b0);
    run_op("min_a",      32'h80000000,  16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 0,  1'b0, 1'b0);
    run_op("dbz",        32'd1234,      16'd0,    16'h0000, 16'h04D2, 1'b1, 1'b1, 0,  1'b0, 1'b0);
    run_op("min_b",      32'h00010000,  16'h8000, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("min_b_rem",  32'hFFFF7FFF,  16'h8000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    run_op("scramble",   32'd7,         16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17, 1'b0, 1'b1);
    run_op("hold",       32'd1000,      16'hFFFD, 16'hFEB3, 16'h0001, 1'b0, 1'b0, 17, 1'b1, 1'b0);

    // Abort an operation in its eighth CALC cycle with an async reset.
    @(negedge clk);
    a = 32'd100; b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_ready", 32'(ready),     32'd0);
    check("abort_quot",  32'(quotient),  32'd0);
    check("abort_rem",   32'(remainder), 32'd0);
    check("abort_ovf",   32'(ovf),       32'd0);
    check("abort_dbz",   32'(dbz),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("after_rst",  32'hFFFFFFCE,  16'hFFFB, 16'h000A, 16'h0000, 1'b0, 1'b0, 17, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
